comp_bist: RTL and testbench

Built-in self-test engine for the combinational N-bit magnitude comparators in this codebase. It drives every operand pair {a, b} exhaustively into a comparator under test, then samples the comparator's alb/aeb/agb outputs. It checks them against an internally computed expected result and reports pass/fail, an error count and the first failing vector. It sits beside a comparator instance and replaces the hand-written stimulus sweep with synthesizable hardware, so the same sweep runs in simulation and on silicon.

---
 rtl/comp_bist_if.sv | 29 ++
 rtl/comp_bist.sv | 144 ++++++++++++++
 tb/tb_comp_bist.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_bist_if.sv
// comp_bist_if: start/status and comparator-under-test signals of the
// comparator self-test engine. slave is the engine side, master is the
// side that owns start and the comparator outputs.
interface comp_bist_if #(
  parameter int WIDTH = 2
) ();
  logic               start;
  logic [WIDTH-1:0]   a_out;
  logic [WIDTH-1:0]   b_out;
  logic               alb_in;
  logic               aeb_in;
  logic               agb_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2*WIDTH:0]   err_cnt;
  logic [2*WIDTH-1:0] fail_vec;
  logic [2:0]         fail_obs;

  modport slave (
    input  start, alb_in, aeb_in, agb_in,
    output a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_obs
  );

  modport master (
    output start, alb_in, aeb_in, agb_in,
    input  a_out, b_out, busy, done, pass, err_cnt, fail_vec, fail_obs
  );
endinterface

// File: rtl/comp_bist.sv
// comp_bist: exhaustive self-test sweep for a WIDTH-bit magnitude comparator.
// Optional first-failure capture (fail_vec/fail_obs) is built only when
// COMP_BIST_FAILCAP_EN is defined; otherwise both outputs are tied to 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_WAIT  | operands driven, letting comparator outputs settle
// ST_CHECK | sample comparator outputs, score, step to next vector
// ST_DONE  | sweep finished, results held until next start
module comp_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  comp_bist_if.slave bus
);
  localparam int VW = 2 * WIDTH;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WW-1:0] WAIT_RLD = WW'(SETTLE - 1);
  localparam logic [WW-1:0] WAIT_ONE = 1;
  localparam logic [VW-1:0] VEC_ONE  = 1;
  localparam logic [VW:0]   ERR_ONE  = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vec_q, vec_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [VW:0]   err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  logic [WIDTH-1:0] a_cur, b_cur;
  logic [2:0]       exp_res, obs_res;
  logic             mismatch;
  logic             start_go;

  assign a_cur    = vec_q[VW-1:WIDTH];
  assign b_cur    = vec_q[WIDTH-1:0];
  assign exp_res  = {a_cur < b_cur, a_cur == b_cur, a_cur > b_cur};
  assign obs_res  = {bus.alb_in, bus.aeb_in, bus.agb_in};
  assign mismatch = (obs_res != exp_res);
  // start only counts when the engine is not mid-sweep
  assign start_go = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // state and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // next-state, sweep stepping and scoring
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_go) begin
          vec_d   = '0;
          err_d   = '0;
          wait_d  = WAIT_RLD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) state_d = ST_CHECK;
        else              wait_d  = wait_q - WAIT_ONE;
      end
      ST_CHECK: begin
        if (mismatch) err_d = err_q + ERR_ONE;
        if (&vec_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          wait_d  = WAIT_RLD;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef COMP_BIST_FAILCAP_EN
  logic [VW-1:0] fvec_q;
  logic [2:0]    fobs_q;

  // latch the vector and outputs of the first failure only (err_q still 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fvec_q <= '0;
      fobs_q <= '0;
    end else if (start_go) begin
      fvec_q <= '0;
      fobs_q <= '0;
    end else if ((state_q == ST_CHECK) && mismatch && (err_q == '0)) begin
      fvec_q <= vec_q;
      fobs_q <= obs_res;
    end
  end

  assign bus.fail_vec = fvec_q;
  assign bus.fail_obs = fobs_q;
`else
  assign bus.fail_vec = '0;
  assign bus.fail_obs = '0;
`endif

  assign bus.a_out   = a_cur;
  assign bus.b_out   = b_cur;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_comp_bist.sv
// tb_comp_bist: drives comp_bist with modelled comparators (golden and
// faulty variants) and checks results against a per-vector reference sweep.
module tb_comp_bist;
  logic clk = 1'b0;
  logic rst;

  // 100 MHz clock
  always #5 clk = ~clk;

  comp_bist_if #(.WIDTH(2)) bus ();
  comp_bist #(.WIDTH(2), .SETTLE(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  comp_bist_if #(.WIDTH(1)) bus2 ();
  comp_bist #(.WIDTH(1), .SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // golden 1-bit comparator beside the SETTLE=3 instance
  always_comb begin
    bus2.alb_in = (bus2.a_out < bus2.b_out);
    bus2.aeb_in = (bus2.a_out == bus2.b_out);
    bus2.agb_in = (bus2.a_out > bus2.b_out);
  end

  int tests = 0;
  int fails = 0;
  int mode  = 0;      // 0 golden, 1 aeb stuck 0, 2 alb/agb swapped, 3 random mask
  bit glitch_en = 1'b0;
  logic [2:0] mask [16];

  function automatic logic [2:0] cmp_fn(int a, int b);
    logic [2:0] g;
    g = {a < b, a == b, a > b};
    case (mode)
      1: g[1] = 1'b0;
      2: g = {g[0], g[1], g[2]};
      3: g = g ^ mask[a * 4 + b];
      default: ;
    endcase
    return g;
  endfunction

  task automatic drive_cmp(input bit in_wait);
    logic [2:0] o;
    o = cmp_fn(int'(bus.a_out), int'(bus.b_out));
    if (glitch_en && in_wait) o = o ^ 3'($urandom_range(1, 7));
    {bus.alb_in, bus.aeb_in, bus.agb_in} = o;
  endtask

  task automatic step(input bit in_wait);
    @(posedge clk);
    #1;
    drive_cmp(in_wait);
  endtask

  // reference: score every {a,b} pair directly
  task automatic model(output int errs, output logic [3:0] fv, output logic [2:0] fo);
    logic [2:0] ideal, obs;
    errs = 0; fv = '0; fo = '0;
    for (int v = 0; v < 16; v++) begin
      ideal = {(v / 4) < (v % 4), (v / 4) == (v % 4), (v / 4) > (v % 4)};
      obs   = cmp_fn(v / 4, v % 4);
      if (obs != ideal) begin
        if (errs == 0) begin fv = 4'(v); fo = obs; end
        errs++;
      end
    end
`ifndef COMP_BIST_FAILCAP_EN
    fv = '0; fo = '0;
`endif
  endtask

  // pulse start, optionally pulse again at edge mid_at, return edges to done
  task automatic run_sweep(input int mid_at, input bit chk_steps, output int lat);
    lat = -1;
    bus.start = 1'b1;
    step(1'b1);
    bus.start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      bus.start = (n == mid_at);
      step((n % 2) == 0);
      if (chk_steps && (n % 2 == 1) && n < 32) begin
        tests++;
        if ({bus.a_out, bus.b_out} !== 4'((n - 1) / 2) || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL step%0d: a/b=%0d/%0d busy=%b, want vec %0d busy=1",
                   n, bus.a_out, bus.b_out, bus.busy, (n - 1) / 2);
        end
      end
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    bus.start = 1'b0;
    tests++;
    if (lat == -1) begin
      fails++;
      $display("FAIL sweep_timeout: done not seen within 200 cycles");
    end
  endtask

  task automatic check_results(input string name, input int lat);
    int errs; logic [3:0] fv; logic [2:0] fo;
    model(errs, fv, fo);
    tests++;
    if (lat !== 32) begin
      fails++; $display("FAIL %s latency: got %0d want 32", name, lat);
    end
    tests++;
    if (bus.err_cnt !== 5'(errs) || bus.pass !== (errs == 0) || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s result: err_cnt=%0d pass=%b busy=%b want err_cnt=%0d pass=%b busy=0",
               name, bus.err_cnt, bus.pass, bus.busy, errs, errs == 0);
    end
    tests++;
    if (bus.fail_vec !== fv || bus.fail_obs !== fo) begin
      fails++;
      $display("FAIL %s capture: fail_vec=%b fail_obs=%b want %b %b",
               name, bus.fail_vec, bus.fail_obs, fv, fo);
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_cnt,
         bus.fail_vec, bus.fail_obs} !== '0) begin
      fails++;
      $display("FAIL reset: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b fo=%b want all 0",
               bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_cnt,
               bus.fail_vec, bus.fail_obs);
    end
  endtask

  task automatic test_golden();
    int lat;
    mode = 0; glitch_en = 1'b0;
    run_sweep(0, 1'b1, lat);
    check_results("golden", lat);
    // results must hold in DONE
    repeat (3) step(1'b0);
    tests++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin
      fails++; $display("FAIL done_hold: done=%b pass=%b want 1 1", bus.done, bus.pass);
    end
  endtask

  task automatic test_fault(input int m, input string name);
    int lat;
    mode = m; glitch_en = 1'b0;
    run_sweep(0, 1'b0, lat);
    check_results(name, lat);
  endtask

  task automatic test_restart_golden();
    int lat;
    mode = 0;
    run_sweep(0, 1'b0, lat);
    check_results("restart_golden", lat);
  endtask

  task automatic test_mid_start();
    int lat;
    mode = 2;
    run_sweep(7, 1'b0, lat);
    check_results("mid_start", lat);
  endtask

  task automatic test_reset_mid_sweep();
    int lat;
    mode = 1;
    bus.start = 1'b1;
    step(1'b1);
    bus.start = 1'b0;
    repeat (10) step(1'b0);
    rst = 1'b1;
    #1;
    test_reset();
    repeat (2) step(1'b0);
    test_reset();
    rst = 1'b0;
    step(1'b0);
    test_reset();
    mode = 0;
    run_sweep(0, 1'b0, lat);
    check_results("after_reset", lat);
  endtask

  task automatic test_start_held();
    int lat;
    mode = 0;
    bus.start = 1'b1;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      step(1'b0);
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    step(1'b0);           // this edge restarts
    tests++;
    if (lat == -1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL start_held_restart: done=%b busy=%b seen=%0d want done=0 busy=1",
               bus.done, bus.busy, lat);
    end
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      step(1'b0);
      if (bus.done === 1'b1) begin lat = n; break; end
    end
    check_results("start_held", lat);
  endtask

  task automatic test_random();
    int lat;
    for (int it = 0; it < 6; it++) begin
      mode = 3; glitch_en = 1'b1;
      for (int i = 0; i < 16; i++) mask[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      run_sweep(0, 1'b0, lat);
      check_results("random", lat);
    end
    glitch_en = 1'b0;
  endtask

  task automatic test_settle();
    int lat;
    lat = -1;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (bus2.done === 1'b1) begin lat = n; break; end
    end
    tests++;
    if (lat !== 16 || bus2.pass !== 1'b1 || bus2.err_cnt !== 3'd0) begin
      fails++;
      $display("FAIL settle3: latency=%0d pass=%b err=%0d want 16 1 0", lat, bus2.pass, bus2.err_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    drive_cmp(1'b0);
    repeat (3) step(1'b0);
    test_reset();
    rst = 1'b0;
    step(1'b0);
    test_reset();
    test_golden();
    test_fault(1, "stuck_aeb");
    test_restart_golden();
    test_fault(2, "swapped");
    test_mid_start();
    test_reset_mid_sweep();
    test_start_held();
    test_random();
    test_settle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
